// File: rtl/a2d_arbiter.sv
//------------------------------------------------------------------------------
// a2d_arbiter
//  Shares one SPI A2D converter among NREQ requesters. Requests are granted
//  round-robin; the winner's 3-bit channel is registered onto chnnl, a single
//  strt_cnv pulse launches the conversion, and the 12-bit result is handed
//  back on res_out together with a one-cycle done pulse to the owner.
//
//  Optional feature macro: A2D_ARB_TIMEOUT_EN
//   defined   : WAIT is bounded by TO_CYCLES clocks; on expiry res_out is
//               forced to zero, the sticky timeout flag is set and the owner
//               still receives its done pulse.
//   undefined : WAIT holds until cnv_cmplt; no timeout port, no counter.
//
//  Parameters
//   NREQ       number of requesters (2..8)
//   TO_CYCLES  WAIT timeout in clk cycles (timeout build only, 1..8192)
//
//  Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   req        level request per requester, held until its done pulse
//   req_chnnl  packed channels, requester i at [3*i+2:3*i]
//   gnt        one-hot owner, high from IDLE exit until DONE exit
//   done       one-cycle pulse to the owner, res_out valid in that cycle
//   res_out    registered result of the last conversion
//   busy       high whenever the arbiter is not idle
//   strt_cnv   one-cycle conversion start to the A2D
//   chnnl      registered channel to the A2D, stable from START to DONE
//   cnv_cmplt  conversion-complete pulse from the A2D
//   res        conversion result from the A2D, valid with cnv_cmplt
//   timeout    sticky timeout flag (A2D_ARB_TIMEOUT_EN only)
//------------------------------------------------------------------------------
module a2d_arbiter #(
   parameter int NREQ      = 4,
   parameter int TO_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_chnnl,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [11:0]          res_out,
   output logic                 busy,
   output logic                 strt_cnv,
   output logic [2:0]           chnnl,
   input  logic                 cnv_cmplt,
   input  logic [11:0]          res
`ifdef A2D_ARB_TIMEOUT_EN
   ,
   output logic                 timeout
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE_HOT_0 = NREQ'(1);

   // Reject configurations the pointer arithmetic and counter cannot cover.
   if ((NREQ < 2) || (NREQ > 8) || (TO_CYCLES < 1) || (TO_CYCLES > 8192)) begin : g_bad_cfg
      $error("a2d_arbiter: NREQ must be 2..8 and TO_CYCLES 1..8192");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   ptr_r;
   logic [PW-1:0]   owner_r;
   logic [PW-1:0]   win_s;
   logic [2:0]      win_chnnl_s;
   logic [PW-1:0]   nxt_ptr_s;

`ifdef A2D_ARB_TIMEOUT_EN
   localparam logic [12:0] TO_LAST = 13'(TO_CYCLES - 1);
   logic [12:0]     to_cnt_r;
`endif

   // First set request at or after the pointer, wrapping NREQ-1 -> 0.
   // Only meaningful when |r; otherwise returns the pointer unchanged.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [PW-1:0]   p);
      logic [PW-1:0] pick;
      logic          found;
      logic [PW:0]   idx;
      pick  = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, p} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) begin
            idx = idx - (PW+1)'(NREQ);
         end else begin
            idx = idx;
         end
         if (!found && r[idx[PW-1:0]]) begin
            pick  = idx[PW-1:0];
            found = 1'b1;
         end else begin
            pick  = pick;
            found = found;
         end
      end
      return pick;
   endfunction

   // Round-robin winner, its channel and the post-DONE pointer value.
   always_comb begin
      win_s       = rr_pick(req, ptr_r);
      win_chnnl_s = req_chnnl[win_s*3 +: 3];
      if (owner_r == PW'(NREQ - 1)) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = owner_r + PW'(1);
      end
   end

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         ptr_r    <= '0;
         owner_r  <= '0;
         gnt      <= '0;
         done     <= '0;
         res_out  <= 12'h000;
         busy     <= 1'b0;
         strt_cnv <= 1'b0;
         chnnl    <= 3'd0;
`ifdef A2D_ARB_TIMEOUT_EN
         to_cnt_r <= 13'd0;
         timeout  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= '0;
               if (|req) begin
                  owner_r  <= win_s;
                  gnt      <= ONE_HOT_0 << win_s;
                  chnnl    <= win_chnnl_s;
                  busy     <= 1'b1;
                  strt_cnv <= 1'b1;
                  state_r  <= ST_START;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_START: begin
               strt_cnv <= 1'b0;
`ifdef A2D_ARB_TIMEOUT_EN
               to_cnt_r <= 13'd0;
`endif
               state_r  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnv_cmplt) begin
                  res_out <= res;
                  done    <= ONE_HOT_0 << owner_r;
                  state_r <= ST_DONE;
`ifdef A2D_ARB_TIMEOUT_EN
               end else if (to_cnt_r == TO_LAST) begin
                  // Converter never answered: release the owner with a zero result.
                  res_out <= 12'h000;
                  timeout <= 1'b1;
                  done    <= ONE_HOT_0 << owner_r;
                  state_r <= ST_DONE;
               end else begin
                  to_cnt_r <= to_cnt_r + 13'd1;
                  state_r  <= ST_WAIT;
               end
`else
               end else begin
                  state_r <= ST_WAIT;
               end
`endif
            end
            ST_DONE: begin
               done    <= '0;
               gnt     <= '0;
               busy    <= 1'b0;
               ptr_r   <= nxt_ptr_s;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               gnt      <= '0;
               done     <= '0;
               busy     <= 1'b0;
               strt_cnv <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_arbiter.sv
//------------------------------------------------------------------------------
// tb_a2d_arbiter
//  Self-checking bench for a2d_arbiter (NREQ=4, TO_CYCLES=16). Inputs are
//  driven and outputs sampled on the falling clock edge. A round-robin model
//  (pointer + "first set request at or after it") predicts every grant.
//  Build with +define+A2D_ARB_TIMEOUT_EN to include the timeout scenario.
//------------------------------------------------------------------------------
module tb_a2d_arbiter;

   localparam int NREQ      = 4;
   localparam int TO_CYCLES = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [3*NREQ-1:0]   req_chnnl;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic [11:0]         res_out;
   logic                busy;
   logic                strt_cnv;
   logic [2:0]          chnnl;
   logic                cnv_cmplt;
   logic [11:0]         res;
`ifdef A2D_ARB_TIMEOUT_EN
   logic                timeout;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int          m_ptr;
   logic [11:0] m_res;

   a2d_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO_CYCLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_chnnl (req_chnnl),
      .gnt       (gnt),
      .done      (done),
      .res_out   (res_out),
      .busy      (busy),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res)
`ifdef A2D_ARB_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
      $fatal(1, "watchdog");
   end

   // Expected winner: first set request at or after ptr, wrapping around.
   function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_ch(input int i, input logic [2:0] v);
      req_chnnl[3*i +: 3] = v;
   endtask

   // Waits (bounded) for strt_cnv; n = falling edges taken.
   task automatic wait_strt(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         n = i;
         if (strt_cnv === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      req_chnnl = '0;
      cnv_cmplt = 1'b0;
      res       = 12'h000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      m_res = 12'h000;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req       = 4'b1111;
      req_chnnl = 12'hFFF;
      cnv_cmplt = 1'b0;
      res       = 12'h000;
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else n_pass++;
      n_checks++; if (done !== 4'b0000) $display("FAIL reset_done got %b exp 0000", done); else n_pass++;
      n_checks++; if (res_out !== 12'h000) $display("FAIL reset_res_out got %h exp 000", res_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_checks++; if (strt_cnv !== 1'b0) $display("FAIL reset_strt got %b exp 0", strt_cnv); else n_pass++;
      n_checks++; if (chnnl !== 3'd0) $display("FAIL reset_chnnl got %0d exp 0", chnnl); else n_pass++;
`ifdef A2D_ARB_TIMEOUT_EN
      n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", timeout); else n_pass++;
`endif
      do_reset();
   endtask

   task automatic test_single();
      set_ch(1, 3'd5);
      req = 4'b0010;
      @(negedge clk);
      n_checks++; if (strt_cnv !== 1'b1) $display("FAIL single_strt got %b exp 1", strt_cnv); else n_pass++;
      n_checks++; if (chnnl !== 3'd5) $display("FAIL single_chnnl got %0d exp 5", chnnl); else n_pass++;
      n_checks++; if (gnt !== 4'b0010) $display("FAIL single_gnt got %b exp 0010", gnt); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (strt_cnv !== 1'b0) $display("FAIL single_strt_width got %b exp 0", strt_cnv); else n_pass++;
      cnv_cmplt = 1'b1;
      res       = 12'hABC;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (done !== 4'b0010) $display("FAIL single_done got %b exp 0010", done); else n_pass++;
      n_checks++; if (res_out !== 12'hABC) $display("FAIL single_res_out got %h exp abc", res_out); else n_pass++;
      req   = '0;
      m_res = 12'hABC;
      m_ptr = 2;
      @(negedge clk);
      n_checks++; if (done !== 4'b0000) $display("FAIL single_done_width got %b exp 0000", done); else n_pass++;
      n_checks++; if (gnt !== 4'b0000) $display("FAIL single_gnt_release got %b exp 0000", gnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_release got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_stray();
      bit ok;
      int n;
      int w;
      // stray completion while idle
      req       = '0;
      res       = 12'h123;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (res_out !== m_res) $display("FAIL stray_idle_res got %h exp %h", res_out, m_res); else n_pass++;
      n_checks++; if (done !== 4'b0000) $display("FAIL stray_idle_done got %b exp 0000", done); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL stray_idle_busy got %b exp 0", busy); else n_pass++;
      // stray completion during START
      set_ch(0, 3'd1);
      req = 4'b0001;
      w   = model_pick(req, m_ptr);
      wait_strt(ok, n);
      n_checks++; if (!ok) $display("FAIL stray_start_wait got no strt_cnv exp strt_cnv"); else n_pass++;
      res       = 12'h5A5;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      @(negedge clk);
      n_checks++; if (done !== 4'b0000) $display("FAIL stray_start_done got %b exp 0000", done); else n_pass++;
      n_checks++; if (res_out !== m_res) $display("FAIL stray_start_res got %h exp %h", res_out, m_res); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL stray_start_busy got %b exp 1", busy); else n_pass++;
      res       = 12'h321;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (done !== oh(w)) $display("FAIL stray_start_final got %b exp %b", done, oh(w)); else n_pass++;
      req   = '0;
      m_res = 12'h321;
      m_ptr = (w + 1) % NREQ;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fairness();
      bit          ok;
      int          n;
      int          w;
      logic [11:0] r;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_ch(i, 3'(i + 4));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         w = model_pick(req, m_ptr);
         wait_strt(ok, n);
         n_checks++; if (!ok) $display("FAIL fair_wait_%0d got no strt_cnv exp strt_cnv", k); else n_pass++;
         n_checks++; if (gnt !== oh(w)) $display("FAIL fair_gnt_%0d got %b exp %b", k, gnt, oh(w)); else n_pass++;
         n_checks++; if (chnnl !== 3'(w + 4)) $display("FAIL fair_chnnl_%0d got %0d exp %0d", k, chnnl, w + 4); else n_pass++;
         if (k > 0) begin
            n_checks++; if (n != 2) $display("FAIL fair_gap_%0d got %0d edges exp 2", k, n); else n_pass++;
         end
         @(negedge clk);
         r         = 12'($urandom);
         res       = r;
         cnv_cmplt = 1'b1;
         @(negedge clk);
         cnv_cmplt = 1'b0;
         n_checks++; if (done !== oh(w)) $display("FAIL fair_done_%0d got %b exp %b", k, done, oh(w)); else n_pass++;
         n_checks++; if ($countones(gnt) != 1) $display("FAIL fair_onehot_%0d got %b exp one-hot", k, gnt); else n_pass++;
         n_checks++; if (res_out !== r) $display("FAIL fair_res_%0d got %h exp %h", k, res_out, r); else n_pass++;
         m_res = r;
         m_ptr = (w + 1) % NREQ;
      end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      bit ok;
      int n;
      do_reset();
      set_ch(0, 3'd2);
      req = 4'b0001;
      wait_strt(ok, n);
      n_checks++; if (!ok) $display("FAIL abort_wait got no strt_cnv exp strt_cnv"); else n_pass++;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      res       = 12'h777;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (done !== 4'b0001) $display("FAIL abort_done got %b exp 0001", done); else n_pass++;
      n_checks++; if (res_out !== 12'h777) $display("FAIL abort_res got %h exp 777", res_out); else n_pass++;
      m_res = 12'h777;
      m_ptr = 1;
      @(negedge clk);
      // reset in the middle of WAIT
      set_ch(1, 3'd4);
      req = 4'b0010;
      wait_strt(ok, n);
      n_checks++; if (!ok) $display("FAIL abort_rst_wait got no strt_cnv exp strt_cnv"); else n_pass++;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (gnt !== 4'b0000) $display("FAIL abort_rst_gnt got %b exp 0000", gnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_rst_busy got %b exp 0", busy); else n_pass++;
      n_checks++; if (chnnl !== 3'd0) $display("FAIL abort_rst_chnnl got %0d exp 0", chnnl); else n_pass++;
      n_checks++; if (res_out !== 12'h000) $display("FAIL abort_rst_res got %h exp 000", res_out); else n_pass++;
      @(negedge clk);
      req   = '0;
      rst_n = 1'b1;
      m_ptr = 0;
      m_res = 12'h000;
      @(negedge clk);
      res       = 12'hFFF;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (done !== 4'b0000) $display("FAIL abort_late_done got %b exp 0000", done); else n_pass++;
      n_checks++; if (res_out !== 12'h000) $display("FAIL abort_late_res got %h exp 000", res_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_late_busy got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_hold();
      bit ok;
      int n;
      set_ch(0, 3'd3);
      req = 4'b0001;
      wait_strt(ok, n);
      n_checks++; if (!ok) $display("FAIL hold_wait got no strt_cnv exp strt_cnv"); else n_pass++;
      n_checks++; if (chnnl !== 3'd3) $display("FAIL hold_chnnl_start got %0d exp 3", chnnl); else n_pass++;
      set_ch(0, 3'd6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (chnnl !== 3'd3) $display("FAIL hold_chnnl_wait%0d got %0d exp 3", i, chnnl); else n_pass++;
      end
      res       = 12'h0F0;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (done !== 4'b0001) $display("FAIL hold_done got %b exp 0001", done); else n_pass++;
      n_checks++; if (chnnl !== 3'd3) $display("FAIL hold_chnnl_done got %0d exp 3", chnnl); else n_pass++;
      m_res = 12'h0F0;
      m_ptr = 1;
      req   = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      bit              ok;
      int              n;
      int              w;
      int              lat;
      logic [NREQ-1:0] cur;
      logic [2:0]      ch [NREQ];
      logic [11:0]     r;
      cur = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
         ch[i] = 3'($urandom);
         set_ch(i, ch[i]);
      end
      req = cur;
      for (int it = 0; it < 40; it++) begin
         w = model_pick(cur, m_ptr);
         wait_strt(ok, n);
         n_checks++; if (!ok) $display("FAIL rand_wait_%0d got no strt_cnv exp strt_cnv", it); else n_pass++;
         n_checks++; if (gnt !== oh(w)) $display("FAIL rand_gnt_%0d got %b exp %b", it, gnt, oh(w)); else n_pass++;
         n_checks++; if (chnnl !== ch[w]) $display("FAIL rand_chnnl_%0d got %0d exp %0d", it, chnnl, ch[w]); else n_pass++;
         @(negedge clk);
         lat = $urandom_range(0, 4);
         for (int j = 0; j < lat; j++) begin
            req_chnnl = 12'($urandom);
            @(negedge clk);
         end
         r         = 12'($urandom);
         res       = r;
         cnv_cmplt = 1'b1;
         @(negedge clk);
         cnv_cmplt = 1'b0;
         n_checks++; if (done !== oh(w)) $display("FAIL rand_done_%0d got %b exp %b", it, done, oh(w)); else n_pass++;
         n_checks++; if (res_out !== r) $display("FAIL rand_res_%0d got %h exp %h", it, res_out, r); else n_pass++;
         n_checks++; if ((gnt !== oh(w)) || (chnnl !== ch[w])) $display("FAIL rand_hold_%0d got gnt %b ch %0d exp gnt %b ch %0d", it, gnt, chnnl, oh(w), ch[w]); else n_pass++;
         m_res = r;
         m_ptr = (w + 1) % NREQ;
         // owner is served; others keep waiting, new requesters may join
         cur = (cur & ~oh(w)) | (4'($urandom) & 4'($urandom));
         if (cur == '0) cur = oh($urandom_range(0, NREQ - 1));
         for (int i = 0; i < NREQ; i++) begin
            ch[i] = 3'($urandom);
            set_ch(i, ch[i]);
         end
         req = cur;
      end
      req = '0;
      repeat (3) @(negedge clk);
   endtask

`ifdef A2D_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int n;
      do_reset();
      set_ch(0, 3'd7);
      req = 4'b0001;
      wait_strt(ok, n);
      n_checks++; if (!ok) $display("FAIL to_wait got no strt_cnv exp strt_cnv"); else n_pass++;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done !== 4'b0000) break;
         n++;
      end
      n_checks++; if (n != TO_CYCLES) $display("FAIL to_cycles got %0d exp %0d", n, TO_CYCLES); else n_pass++;
      n_checks++; if (done !== 4'b0001) $display("FAIL to_done got %b exp 0001", done); else n_pass++;
      n_checks++; if (res_out !== 12'h000) $display("FAIL to_res got %h exp 000", res_out); else n_pass++;
      n_checks++; if (timeout !== 1'b1) $display("FAIL to_flag got %b exp 1", timeout); else n_pass++;
      req   = 4'b0010;
      m_ptr = 1;
      wait_strt(ok, n);
      n_checks++; if (gnt !== 4'b0010) $display("FAIL to_next_gnt got %b exp 0010", gnt); else n_pass++;
      n_checks++; if (timeout !== 1'b1) $display("FAIL to_sticky got %b exp 1", timeout); else n_pass++;
      @(negedge clk);
      res       = 12'h456;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
      n_checks++; if (res_out !== 12'h456) $display("FAIL to_next_res got %h exp 456", res_out); else n_pass++;
      n_checks++; if (timeout !== 1'b1) $display("FAIL to_sticky_done got %b exp 1", timeout); else n_pass++;
      req = '0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      req_chnnl = '0;
      cnv_cmplt = 1'b0;
      res       = 12'h000;
      m_ptr     = 0;
      m_res     = 12'h000;
      test_reset();
      test_single();
      test_stray();
      test_fairness();
      test_abort();
      test_hold();
      test_random();
`ifdef A2D_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
